// File: rtl/udp_lut_engine_if.sv
// Configuration and sweep port bundle for udp_lut_engine.
// The master side writes tables and starts sweeps; the slave side is the engine.
interface udp_lut_engine_if #(
    parameter int unsigned N_IN = 3,
    parameter int unsigned N_CH = 2
);
    localparam int unsigned TW = 2 ** (N_IN + 1);
    localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic            cfg_valid;
    logic            cfg_ready;
    logic [CW-1:0]   cfg_ch;
    logic            cfg_mode;
    logic [TW-1:0]   cfg_table;

    logic            sweep_start;
    logic [CW-1:0]   sweep_ch;
    logic            sweep_busy;
    logic            sweep_valid;
    logic [N_IN-1:0] sweep_idx;
    logic            sweep_f;
    logic            sweep_done;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_table, sweep_start, sweep_ch,
        input  cfg_ready, sweep_busy, sweep_valid, sweep_idx, sweep_f, sweep_done
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_table, sweep_start, sweep_ch,
        output cfg_ready, sweep_busy, sweep_valid, sweep_idx, sweep_f, sweep_done
    );
endinterface

// File: rtl/udp_lut_engine.sv
// Multi-channel run-time-loadable truth-table engine with a truth-table sweep reader.
// Each channel evaluates table[{q & mode, x}] into a registered output f (== q).
module udp_lut_engine #(
    parameter int unsigned N_IN = 3,
    parameter int unsigned N_CH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] x,
    input  logic            en,
    output logic [N_CH-1:0] f,
    udp_lut_engine_if.slave bus
);
    localparam int unsigned TW = 2 ** (N_IN + 1);
    localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

    typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

    state_e          state_q, state_d;
    logic [N_IN-1:0] cnt_q, cnt_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic            sweep_f_q, sweep_f_d;

    logic [TW-1:0]   tbl_q [N_CH];
    logic [TW-1:0]   tbl_d [N_CH];
    logic [N_CH-1:0] mode_q, mode_d;
    logic [N_CH-1:0] f_q, f_d;
    logic            cfg_acc;

    // Tables may only change while no sweep is reading them.
    assign bus.cfg_ready = (state_q == StIdle);
    assign cfg_acc       = bus.cfg_valid && bus.cfg_ready;

    // Channel next state: an accepted write loads table/mode and clears q, overriding evaluation.
    // Channel indices with no match (>= N_CH) simply fall through and are discarded.
    always_comb begin
        tbl_d  = tbl_q;
        mode_d = mode_q;
        f_d    = f_q;
        for (int c = 0; c < N_CH; c++) begin
            if (cfg_acc && (bus.cfg_ch == CW'(c))) begin
                tbl_d[c]  = bus.cfg_table;
                mode_d[c] = bus.cfg_mode;
                f_d[c]    = 1'b0;
            end else if (en) begin
                f_d[c] = tbl_q[c][{mode_q[c] & f_q[c], x}];
            end
        end
    end

    // Sweep FSM next state: IDLE -> SWEEP (2**N_IN cycles) -> DONE (1 cycle) -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        unique case (state_q)
            StIdle: begin
                if (bus.sweep_start) begin
                    state_d = StSweep;
                    cnt_d   = '0;
                    ch_d    = bus.sweep_ch;
                end
            end
            StSweep: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sweep data looks ahead at next-state table so a same-edge write is already visible.
    always_comb begin
        sweep_f_d = 1'b0;
        if (state_d == StSweep) begin
            for (int c = 0; c < N_CH; c++) begin
                if (ch_d == CW'(c)) begin
                    sweep_f_d = tbl_d[c][{1'b0, cnt_d}];
                end
            end
        end
    end

    // State registers for channels and the sweep engine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ch_q      <= '0;
            sweep_f_q <= 1'b0;
            mode_q    <= '0;
            f_q       <= '0;
            for (int c = 0; c < N_CH; c++) begin
                tbl_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            sweep_f_q <= sweep_f_d;
            mode_q    <= mode_d;
            f_q       <= f_d;
            for (int c = 0; c < N_CH; c++) begin
                tbl_q[c] <= tbl_d[c];
            end
        end
    end

    assign f               = f_q;
    assign bus.sweep_busy  = (state_q != StIdle);
    assign bus.sweep_valid = (state_q == StSweep);
    assign bus.sweep_idx   = cnt_q;
    assign bus.sweep_f     = sweep_f_q;
    assign bus.sweep_done  = (state_q == StSweep) && (cnt_q == LAST_IDX);
endmodule

// File: tb/tb_udp_lut_engine.sv
// Self-checking bench for udp_lut_engine: channel evaluation, config, sweep scoreboard, reset.
module tb_udp_lut_engine;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] x;
    logic       en;
    logic [1:0] f;
    logic [2:0] f3;

    udp_lut_engine_if #(.N_IN(3), .N_CH(2)) bus ();
    udp_lut_engine_if #(.N_IN(3), .N_CH(3)) bus3 ();

    udp_lut_engine #(.N_IN(3), .N_CH(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .en    (en),
        .f     (f),
        .bus   (bus)
    );

    // Three-channel instance so an out-of-range channel number is expressible.
    udp_lut_engine #(.N_IN(3), .N_CH(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .en    (en),
        .f     (f3),
        .bus   (bus3)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] idx;
        logic       f;
        logic       done;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sweep monitor: pops one expected entry per valid beat; outside beats outputs must be 0.
    always @(negedge clk) begin
        if (bus.sweep_valid === 1'b1) begin
            check_eq("sb_nonempty", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check_eq("sweep_idx", 32'(bus.sweep_idx), 32'(mon_e.idx));
                check_eq("sweep_f", 32'(bus.sweep_f), 32'(mon_e.f));
                check_eq("sweep_done", 32'(bus.sweep_done), 32'(mon_e.done));
            end
        end else begin
            check_eq("idle_idx", 32'(bus.sweep_idx), 0);
            check_eq("idle_f", 32'(bus.sweep_f), 0);
            check_eq("idle_done", 32'(bus.sweep_done), 0);
        end
    end

    task automatic cfg_write(input logic ch, input logic mode, input logic [15:0] tbl);
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = ch;
        bus.cfg_mode  = mode;
        bus.cfg_table = tbl;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] tbl);
        sb_t e;
        for (int i = 0; i < 8; i++) begin
            e.idx  = 3'(i);
            e.f    = tbl[i];
            e.done = (i == 7);
            sb_q.push_back(e);
        end
    endtask

    // Runs one sweep; optionally pokes a config write and a second start mid-sweep,
    // or issues a config write on the same cycle as the start.
    task automatic run_sweep(input logic ch, input logic [15:0] exp_tbl, input bit poke,
                             input bit with_cfg, input logic [15:0] cfg_tbl);
        int busy_n  = 0;
        int rdy_low = 0;
        int guard   = 0;
        push_exp(exp_tbl);
        bus.sweep_start = 1'b1;
        bus.sweep_ch    = ch;
        if (with_cfg) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_ch    = ch;
            bus.cfg_mode  = 1'b0;
            bus.cfg_table = cfg_tbl;
        end
        tick();
        bus.sweep_start = 1'b0;
        bus.cfg_valid   = 1'b0;
        while (bus.sweep_busy && guard < 40) begin
            busy_n++;
            guard++;
            if (!bus.cfg_ready) rdy_low++;
            if (poke && busy_n == 3) begin
                bus.cfg_valid   = 1'b1;
                bus.cfg_ch      = 1'b1;
                bus.cfg_mode    = 1'b1;
                bus.cfg_table   = 16'h00FF;
                bus.sweep_start = 1'b1;
                bus.sweep_ch    = 1'b0;
            end else begin
                bus.cfg_valid   = 1'b0;
                bus.sweep_start = 1'b0;
            end
            tick();
        end
        bus.cfg_valid   = 1'b0;
        bus.sweep_start = 1'b0;
        check_eq("sweep_cycles", busy_n, 9);
        check_eq("ready_low_cycles", rdy_low, 9);
        check_eq("ready_after", 32'(bus.cfg_ready), 1);
        check_eq("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int g;
        rst_n = 1'b0;
        x = '0;
        en = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_ch = '0; bus.cfg_mode = 1'b0; bus.cfg_table = '0;
        bus.sweep_start = 1'b0; bus.sweep_ch = '0;
        bus3.cfg_valid = 1'b0; bus3.cfg_ch = '0; bus3.cfg_mode = 1'b0; bus3.cfg_table = '0;
        bus3.sweep_start = 1'b0; bus3.sweep_ch = '0;

        // Reset state
        #12;
        check_eq("rst_f", 32'(f), 0);
        check_eq("rst_busy", 32'(bus.sweep_busy), 0);
        check_eq("rst_valid", 32'(bus.sweep_valid), 0);
        check_eq("rst_ready", 32'(bus.cfg_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        tick();

        // XOR3 on ch0, combinational mode
        cfg_write(1'b0, 1'b0, 16'h0096);
        for (int i = 0; i < 8; i++) begin
            x = 3'(i);
            tick();
            check_eq("xor3", 32'(f[0]), 32'(^x));
        end

        // Majority on ch1 alongside XOR3 on ch0, then en=0 freeze
        cfg_write(1'b1, 1'b0, 16'h00E8);
        x = 3'b011;
        tick();
        check_eq("xor_maj", 32'(f), 32'h2);
        en = 1'b0;
        x = 3'b101;
        tick();
        check_eq("en0_hold_a", 32'(f), 32'h2);
        x = 3'b000;
        tick();
        check_eq("en0_hold_b", 32'(f), 32'h2);
        en = 1'b1;

        // T flop on x[0], sequential mode
        x = 3'b000;
        cfg_write(1'b0, 1'b1, 16'h55AA);
        check_eq("tff_cleared", 32'(f[0]), 0);
        x = 3'b001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("tff_toggle", 32'(f[0]), 32'((i % 2) == 0));
        end
        x = 3'b000;
        tick();
        check_eq("tff_hold_a", 32'(f[0]), 1);
        tick();
        check_eq("tff_hold_b", 32'(f[0]), 1);
        cfg_write(1'b0, 1'b1, 16'h55AA);
        check_eq("tff_reconfig_clr", 32'(f[0]), 0);

        // Sweep ch1 with a blocked config write and an ignored restart mid-sweep
        run_sweep(1'b1, 16'h00E8, 1'b1, 1'b0, 16'h0000);
        x = 3'b011;
        tick();
        check_eq("ch1_kept_a", 32'(f[1]), 1);
        x = 3'b100;
        tick();
        check_eq("ch1_kept_b", 32'(f[1]), 0);

        // Same-cycle config write and sweep start: sweep sees the new table
        run_sweep(1'b0, 16'h00FF, 1'b0, 1'b1, 16'h00FF);

        // Out-of-range channels on the three-channel instance
        x = 3'b000;
        for (int c = 0; c < 4; c++) begin
            bus3.cfg_valid = 1'b1;
            bus3.cfg_ch    = 2'(c);
            bus3.cfg_table = (c == 3) ? 16'h0000 : 16'h00FF;
            tick();
        end
        bus3.cfg_valid   = 1'b0;
        bus3.sweep_start = 1'b1;
        bus3.sweep_ch    = 2'd3;
        tick();
        bus3.sweep_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_eq("oor_valid", 32'(bus3.sweep_valid), 1);
            check_eq("oor_idx", 32'(bus3.sweep_idx), 32'(i));
            check_eq("oor_f", 32'(bus3.sweep_f), 0);
            check_eq("oor_done", 32'(bus3.sweep_done), 32'(i == 7));
            tick();
        end
        check_eq("oor_done_state", 32'({bus3.sweep_busy, bus3.sweep_valid}), 32'h2);
        tick();
        check_eq("oor_idle_ready", 32'(bus3.cfg_ready), 1);
        check_eq("oor_f3", 32'(f3), 32'h7);

        // Reset mid-sweep at idx 4
        x = 3'b011;
        tick();
        check_eq("pre_rst_f", 32'(f), 32'h3);
        push_exp(16'h00E8);
        bus.sweep_start = 1'b1;
        bus.sweep_ch    = 1'b1;
        tick();
        bus.sweep_start = 1'b0;
        g = 0;
        while (bus.sweep_idx !== 3'd4 && g < 20) begin
            g++;
            tick();
        end
        check_eq("reach_idx4", 32'(bus.sweep_idx), 4);
        check_eq("sb_left", sb_q.size(), 4);
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 32'(bus.sweep_busy), 0);
        check_eq("arst_valid", 32'(bus.sweep_valid), 0);
        check_eq("arst_done", 32'(bus.sweep_done), 0);
        check_eq("arst_f", 32'(f), 0);
        check_eq("arst_ready", 32'(bus.cfg_ready), 1);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        x = 3'b111;
        tick();
        check_eq("post_rst_f", 32'(f), 0);
        run_sweep(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
        run_sweep(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
